rcb_frl_crc_framer: RTL

RCB_FRL_CRC_FRAMER -- requirements
Module: rcb_frl_crc_framer

---
 rtl/rcb_frl_crc_framer_pkg.sv | 32 +++
 rtl/rcb_frl_crc_framer_crc_gen.sv | 24 ++
 rtl/rcb_frl_crc_framer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rcb_frl_crc_framer_pkg.sv
// Shared FRL framer definitions: FSM encoding, frame geometry, sync byte and CRC polynomial.
package rcb_frl_crc_framer_pkg;

    localparam int unsigned FRAME_PAYLOAD_BYTES = 6;
    localparam logic [2:0]  LAST_IDX            = 3'(FRAME_PAYLOAD_BYTES - 1);
    localparam logic [7:0]  DEFAULT_SYNC_BYTE   = 8'hF5;
    localparam logic [7:0]  CRC8_POLY           = 8'hD5;

    typedef enum logic [2:0] {
        StCollect = 3'd0,
        StCalc    = 3'd1,
        StSync    = 3'd2,
        StData    = 3'd3,
        StCrc     = 3'd4
    } frl_state_e;

    function automatic logic [7:0] frl_payload_byte(input logic [47:0] d, input logic [2:0] k);
        logic [7:0] b;
        b = 8'h00;
        case (k)
            3'd0:    b = d[7:0];
            3'd1:    b = d[15:8];
            3'd2:    b = d[23:16];
            3'd3:    b = d[31:24];
            3'd4:    b = d[39:32];
            3'd5:    b = d[47:40];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rcb_frl_crc_framer_crc_gen.sv
// Combinational CRC-8 (poly 0xD5, zero init) over the 48-bit payload word, D[47] shifted in first.
module RCB_FRL_CRC_gen
    import rcb_frl_crc_framer_pkg::*;
(
    input  logic [47:0] i_data,
    output logic [7:0]  o_crc
);

    logic [7:0] w_acc;

    always_comb begin
        w_acc = 8'h00;
        for (int i = 47; i >= 0; i--) begin
            if (w_acc[7] ^ i_data[i]) begin
                w_acc = {w_acc[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                w_acc = {w_acc[6:0], 1'b0};
            end
        end
    end

    assign o_crc = w_acc;

endmodule

// File: rtl/rcb_frl_crc_framer.sv
// Collects six payload bytes, appends a CRC-8 and streams the frame (optional sync byte first).
module rcb_frl_crc_framer
    import rcb_frl_crc_framer_pkg::*;
#(
    parameter bit         SYNC_EN   = 1'b1,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        IN_ABORT,
    output logic [7:0]  OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OUT_SOF,
    output logic        OUT_EOF,
    output logic        BUSY,
    output logic [15:0] FRAME_CNT
);

    frl_state_e  r_state;
    logic [2:0]  r_idx;
    logic [47:0] r_data;
    logic [7:0]  r_crc;
    logic [7:0]  r_out_data;
    logic        r_out_valid;
    logic        r_out_sof;
    logic        r_out_eof;
    logic        r_in_ready;
    logic [15:0] r_frame_cnt;

    logic [7:0]  w_crc;
    logic        w_in_fire;
    logic        w_out_fire;

    RCB_FRL_CRC_gen u_crc_gen (
        .i_data (r_data),
        .o_crc  (w_crc)
    );

    assign w_in_fire  = IN_VALID & r_in_ready;
    assign w_out_fire = r_out_valid & OUT_READY;

    // r_idx counts accepted bytes in StCollect and emitted payload bytes in StData.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= StCollect;
            r_idx       <= 3'd0;
            r_data      <= 48'h0;
            r_crc       <= 8'h00;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_in_ready  <= 1'b0;
            r_frame_cnt <= 16'h0000;
        end else begin
            case (r_state)
                StCollect: begin
                    r_in_ready <= 1'b1;
                    if (IN_ABORT) begin
                        r_idx <= 3'd0;
                    end else if (w_in_fire) begin
                        r_data[{r_idx, 3'b000} +: 8] <= IN_DATA;
                        if (r_idx == LAST_IDX) begin
                            r_idx      <= 3'd0;
                            r_in_ready <= 1'b0;
                            r_state    <= StCalc;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                StCalc: begin
                    r_crc       <= w_crc;
                    r_out_valid <= 1'b1;
                    r_out_sof   <= 1'b1;
                    if (SYNC_EN) begin
                        r_out_data <= SYNC_BYTE;
                        r_state    <= StSync;
                    end else begin
                        r_out_data <= r_data[7:0];
                        r_state    <= StData;
                    end
                end
                StSync: begin
                    if (w_out_fire) begin
                        r_out_data <= r_data[7:0];
                        r_out_sof  <= 1'b0;
                        r_state    <= StData;
                    end
                end
                StData: begin
                    if (w_out_fire) begin
                        r_out_sof <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_out_data <= r_crc;
                            r_out_eof  <= 1'b1;
                            r_state    <= StCrc;
                        end else begin
                            r_idx      <= r_idx + 3'd1;
                            r_out_data <= frl_payload_byte(r_data, r_idx + 3'd1);
                        end
                    end
                end
                StCrc: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_out_eof   <= 1'b0;
                        r_out_data  <= 8'h00;
                        r_idx       <= 3'd0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_in_ready  <= 1'b1;
                        r_state     <= StCollect;
                    end
                end
                default: begin
                    r_state <= StCollect;
                end
            endcase
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_DATA  = r_out_data;
    assign OUT_VALID = r_out_valid;
    assign OUT_SOF   = r_out_sof;
    assign OUT_EOF   = r_out_eof;
    assign FRAME_CNT = r_frame_cnt;
    assign BUSY      = (r_state != StCollect) || (r_idx != 3'd0);

endmodule
